pcs_tx_sched: RTL and testbench

- Transmit-side scheduler that sits between the MAC XGMII TX port and the 64b/66b encoder (32-bit XGMII, two words per 66-bit block).
- Tracks block phase and owns the gearbox sequence counter.
- Inserts the periodic two-cycle gearbox pause and back-pressures the MAC during it.
- Forces an idle fill after reset or link loss. Switches between MAC data and forced idle only on block boundaries outside frames.

---
 rtl/pcs_tx_sched.sv | 145 ++++++++++++++
 tb/tb_pcs_tx_sched.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_tx_sched.sv
// pcs_tx_sched: XGMII TX scheduler ahead of the 64b/66b encoder. It tracks the block
// phase, owns the gearbox sequence and pause, and selects MAC data or a forced idle fill.
module pcs_tx_sched #(
    parameter int DATA_WIDTH  = 32,
    parameter int CTRL_WIDTH  = DATA_WIDTH / 8,
    parameter int SEQ_MAX     = 32,
    parameter int IDLE_BLOCKS = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_link_up,
    input  logic [DATA_WIDTH-1:0] i_mac_txd,
    input  logic [CTRL_WIDTH-1:0] i_mac_txc,
    input  logic                  i_mac_valid,
    output logic                  o_mac_ready,
    output logic [DATA_WIDTH-1:0] o_xgmii_txd,
    output logic [CTRL_WIDTH-1:0] o_xgmii_txc,
    output logic                  o_xgmii_valid,
    output logic [5:0]            o_gearbox_seq,
    output logic                  o_gearbox_pause,
    output logic [1:0]            o_state,
    output logic                  o_underflow
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] IDLE_WORD     = {CTRL_WIDTH{8'h07}};
    localparam logic [DATA_WIDTH-1:0] ERROR_WORD    = {CTRL_WIDTH{8'hFE}};
    localparam logic [CTRL_WIDTH-1:0] ALL_CTRL      = '1;
    localparam logic [5:0]            SEQ_LAST      = 6'(SEQ_MAX);
    localparam logic [5:0]            SEQ_PRE_PAUSE = 6'(SEQ_MAX - 1);
    localparam logic [7:0]            FILL_TARGET   = 8'(IDLE_BLOCKS);

    logic       r_phase;
    logic [5:0] r_seq;
    logic [7:0] r_fill_cnt;
    state_t     r_state;
    logic       r_pend;
    state_t     r_pend_state;

    logic   w_pause;
    logic   w_decide;
    logic   w_land;
    logic   w_boundary_idle;
    logic   w_fill_tick;
    state_t w_next_state;

    assign w_pause  = (r_seq == SEQ_LAST);
    // Decisions are made on the lower word of a non-pause block and land on the next
    // block edge; the edge into a pause block is skipped so the switch lands after it.
    assign w_decide = !r_phase && !w_pause;
    assign w_land   = r_phase && (r_seq != SEQ_PRE_PAUSE);

    assign w_boundary_idle = w_decide && i_mac_valid &&
                             (i_mac_txc == ALL_CTRL) && (i_mac_txd == IDLE_WORD);
    assign w_fill_tick     = r_phase && !w_pause && (r_state == ST_FILL);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would make results depend on statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_phase    <= 1'b0;
            r_seq      <= 6'd0;
            r_fill_cnt <= 8'd0;
        end else begin
            r_phase <= ~r_phase;
            if (r_phase) begin
                r_seq <= (r_seq == SEQ_LAST) ? 6'd0 : r_seq + 6'd1;
            end
            if (w_land && r_pend && (r_pend_state == ST_FILL)) begin
                r_fill_cnt <= 8'd0;
            end else if (w_fill_tick && (r_fill_cnt != FILL_TARGET)) begin
                r_fill_cnt <= r_fill_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_INIT;
            r_pend       <= 1'b0;
            r_pend_state <= ST_INIT;
        end else if (w_decide && (w_next_state != r_state)) begin
            r_pend       <= 1'b1;
            r_pend_state <= w_next_state;
        end else if (w_land && r_pend) begin
            r_state <= r_pend_state;
            r_pend  <= 1'b0;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_INIT: begin
                if (i_enable) w_next_state = ST_FILL;
            end
            ST_FILL: begin
                if (!i_enable) begin
                    w_next_state = ST_INIT;
                end else if (i_link_up && (r_fill_cnt == FILL_TARGET) && w_boundary_idle) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if ((!i_enable || !i_link_up) && w_boundary_idle) w_next_state = ST_FILL;
            end
            default: w_next_state = ST_INIT;
        endcase
    end

    // Reset gates the handshake outputs directly so they drop without waiting for an edge.
    always_comb begin
        o_xgmii_txd   = IDLE_WORD;
        o_xgmii_txc   = ALL_CTRL;
        o_xgmii_valid = 1'b0;
        o_mac_ready   = 1'b0;
        o_underflow   = 1'b0;
        if (!i_reset) begin
            o_xgmii_valid = !w_pause;
            o_mac_ready   = !w_pause;
            if (r_state == ST_RUN) begin
                if (!w_pause && !i_mac_valid) begin
                    o_xgmii_txd = ERROR_WORD;
                    o_xgmii_txc = ALL_CTRL;
                    o_underflow = 1'b1;
                end else begin
                    o_xgmii_txd = i_mac_txd;
                    o_xgmii_txc = i_mac_txc;
                end
            end
        end
    end

    assign o_gearbox_seq   = r_seq;
    assign o_gearbox_pause = w_pause;
    assign o_state         = r_state;

endmodule

// File: tb/tb_pcs_tx_sched.sv
// tb_pcs_tx_sched: scenario tasks for pcs_tx_sched with a block-cadence model and a
// scoreboard of expected encoder words pushed when the MAC word is accepted.
module tb_pcs_tx_sched;

    localparam logic [31:0] IDLE_D  = 32'h07070707;
    localparam logic [31:0] ERR_D   = 32'hFEFEFEFE;
    localparam int          SEQ_MOD = 33;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic        i_link_up;
    logic [31:0] i_mac_txd;
    logic [3:0]  i_mac_txc;
    logic        i_mac_valid;
    logic        o_mac_ready;
    logic [31:0] o_xgmii_txd;
    logic [3:0]  o_xgmii_txc;
    logic        o_xgmii_valid;
    logic [5:0]  o_gearbox_seq;
    logic        o_gearbox_pause;
    logic [1:0]  o_state;
    logic        o_underflow;

    int checks = 0;
    int errors = 0;
    int cyc;
    logic [35:0] sb[$];

    pcs_tx_sched dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_link_up      (i_link_up),
        .i_mac_txd      (i_mac_txd),
        .i_mac_txc      (i_mac_txc),
        .i_mac_valid    (i_mac_valid),
        .o_mac_ready    (o_mac_ready),
        .o_xgmii_txd    (o_xgmii_txd),
        .o_xgmii_txc    (o_xgmii_txc),
        .o_xgmii_valid  (o_xgmii_valid),
        .o_gearbox_seq  (o_gearbox_seq),
        .o_gearbox_pause(o_gearbox_pause),
        .o_state        (o_state),
        .o_underflow    (o_underflow)
    );

    always #5 i_clk = ~i_clk;

    // Cycle index since reset release; cadence model is derived from it alone.
    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    function automatic int exp_phase();
        return cyc % 2;
    endfunction

    function automatic int exp_seq();
        return (cyc / 2) % SEQ_MOD;
    endfunction

    function automatic logic exp_pause();
        return (exp_seq() == SEQ_MOD - 1);
    endfunction

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic mac_idle();
        i_mac_txd   = IDLE_D;
        i_mac_txc   = 4'hF;
        i_mac_valid = 1'b1;
    endtask

    // Presents one MAC word until accepted; expected encoder word goes to the scoreboard.
    task automatic mac_word(input logic [31:0] d, input logic [3:0] c, input logic v,
                            input logic [31:0] ed, input logic [3:0] ec,
                            input logic exp_uf, input int exp_st, input string tag);
        bit          done;
        logic [35:0] exp_w;
        done = 0;
        i_mac_txd   = d;
        i_mac_txc   = c;
        i_mac_valid = v;
        for (int t = 0; t < 4 && !done; t++) begin
            @(negedge i_clk);
            if (exp_pause()) begin
                checks++;
                if ({o_gearbox_pause, o_xgmii_valid, o_mac_ready, o_underflow} !== 4'b1000) begin
                    errors++;
                    $display("FAIL %s_pause cyc=%0d got p/v/r/u=%b%b%b%b want 1000", tag, cyc,
                             o_gearbox_pause, o_xgmii_valid, o_mac_ready, o_underflow);
                end
            end else begin
                checks++;
                if (o_mac_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_ready cyc=%0d got %b want 1", tag, cyc, o_mac_ready);
                end
                sb.push_back({ed, ec});
                done = 1;
                checks++;
                if (o_underflow !== exp_uf) begin
                    errors++;
                    $display("FAIL %s_underflow cyc=%0d got %b want %b", tag, cyc, o_underflow, exp_uf);
                end
            end
            if (o_xgmii_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s_unexpected cyc=%0d got %h/%h want no word", tag, cyc,
                             o_xgmii_txd, o_xgmii_txc);
                end else begin
                    exp_w = sb.pop_front();
                    if ({o_xgmii_txd, o_xgmii_txc} !== exp_w) begin
                        errors++;
                        $display("FAIL %s_data cyc=%0d got %h/%h want %h/%h", tag, cyc,
                                 o_xgmii_txd, o_xgmii_txc, exp_w[35:4], exp_w[3:0]);
                    end
                end
            end
            if (exp_st >= 0) begin
                checks++;
                if (o_state !== 2'(exp_st)) begin
                    errors++;
                    $display("FAIL %s_state cyc=%0d got %0d want %0d", tag, cyc, o_state, exp_st);
                end
            end
            next_cycle();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout cyc=%0d word never accepted", tag, cyc);
        end
    endtask

    task automatic align_to(input int seq, input string tag);
        int n;
        n = 0;
        mac_idle();
        while (!(exp_seq() == seq && exp_phase() == 0) && n < 200) begin
            next_cycle();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_align cyc=%0d never reached seq %0d", tag, cyc, seq);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({o_xgmii_txd, o_xgmii_txc} !== {IDLE_D, 4'hF}) begin
            errors++;
            $display("FAIL %s_data got %h/%h want %h/f", tag, o_xgmii_txd, o_xgmii_txc, IDLE_D);
        end
        checks++;
        if ({o_xgmii_valid, o_mac_ready, o_gearbox_pause, o_underflow} !== 4'b0000) begin
            errors++;
            $display("FAIL %s_flags got v/r/p/u=%b%b%b%b want 0000", tag,
                     o_xgmii_valid, o_mac_ready, o_gearbox_pause, o_underflow);
        end
        checks++;
        if ({o_gearbox_seq, o_state} !== 8'h00) begin
            errors++;
            $display("FAIL %s_seq_state got seq=%0d state=%0d want 0/0", tag, o_gearbox_seq, o_state);
        end
    endtask

    task automatic test_reset();
        i_reset     = 1'b1;
        i_enable    = 1'b1;
        i_link_up   = 1'b1;
        i_mac_txd   = 32'hDEADBEEF;
        i_mac_txc   = 4'h0;
        i_mac_valid = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check_reset_outputs("reset");
        @(posedge i_clk);
        #1;
        mac_idle();
        i_reset = 1'b0;
    endtask

    // Expects to start right after reset release (cycle 0).
    task automatic test_fill_to_run(input string tag);
        int exp_st;
        i_enable  = 1'b1;
        i_link_up = 1'b1;
        mac_idle();
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            exp_st = (cyc < 2) ? 0 : (cyc < 36) ? 1 : 2;
            checks++;
            if (o_state !== 2'(exp_st)) begin
                errors++;
                $display("FAIL %s_state cyc=%0d got %0d want %0d", tag, cyc, o_state, exp_st);
            end
            checks++;
            if ({o_xgmii_txd, o_xgmii_txc, o_xgmii_valid, o_mac_ready} !== {IDLE_D, 4'hF, 2'b11}) begin
                errors++;
                $display("FAIL %s_out cyc=%0d got %h/%h v=%b r=%b want %h/f v=1 r=1", tag, cyc,
                         o_xgmii_txd, o_xgmii_txc, o_xgmii_valid, o_mac_ready, IDLE_D);
            end
            next_cycle();
        end
    endtask

    task automatic test_free_run();
        logic p;
        mac_idle();
        for (int k = 0; k < 200; k++) begin
            @(negedge i_clk);
            p = exp_pause();
            checks++;
            if (o_gearbox_seq !== 6'(exp_seq())) begin
                errors++;
                $display("FAIL free_seq cyc=%0d got %0d want %0d", cyc, o_gearbox_seq, exp_seq());
            end
            checks++;
            if ({o_gearbox_pause, o_xgmii_valid, o_mac_ready} !== {p, !p, !p}) begin
                errors++;
                $display("FAIL free_pause cyc=%0d got p/v/r=%b%b%b want %b%b%b", cyc,
                         o_gearbox_pause, o_xgmii_valid, o_mac_ready, p, !p, !p);
            end
            if (!p) begin
                checks++;
                if ({o_xgmii_txd, o_xgmii_txc, o_state} !== {IDLE_D, 4'hF, 2'd2}) begin
                    errors++;
                    $display("FAIL free_idle cyc=%0d got %h/%h state=%0d want %h/f state=2", cyc,
                             o_xgmii_txd, o_xgmii_txc, o_state, IDLE_D);
                end
            end
            next_cycle();
        end
    endtask

    task automatic send_frame(input string tag, input int drop_at);
        logic [31:0] d;
        logic [3:0]  c;
        for (int i = 0; i < 17; i++) begin
            if (i == 0) begin
                d = 32'h555555FB;
                c = 4'b0001;
            end else if (i == 16) begin
                d = 32'h070707FD;
                c = 4'b1111;
            end else begin
                d = 32'hA0B0C000 + 32'(i * 32'h01010101);
                c = 4'b0000;
            end
            if (i == drop_at) i_link_up = 1'b0;
            mac_word(d, c, 1'b1, d, c, 1'b0, 2, tag);
        end
    endtask

    task automatic test_frame_over_pause();
        align_to(28, "frame");
        send_frame("frame", -1);
        mac_word(IDLE_D, 4'hF, 1'b1, IDLE_D, 4'hF, 1'b0, 2, "frame_tail");
        mac_word(IDLE_D, 4'hF, 1'b1, IDLE_D, 4'hF, 1'b0, 2, "frame_tail");
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL frame_sb_left got %0d words want 0", sb.size());
        end
    endtask

    task automatic test_link_drop();
        align_to(2, "link");
        send_frame("link_frame", 5);
        mac_word(IDLE_D, 4'hF, 1'b1, IDLE_D, 4'hF, 1'b0, 2, "link_hi");
        mac_word(IDLE_D, 4'hF, 1'b1, IDLE_D, 4'hF, 1'b0, 2, "link_b");
        mac_word(IDLE_D, 4'hF, 1'b1, IDLE_D, 4'hF, 1'b0, 2, "link_b_hi");
        mac_word(32'h11223344, 4'h0, 1'b1, IDLE_D, 4'hF, 1'b0, 1, "link_fill_lo");
        mac_word(32'h55667788, 4'h0, 1'b1, IDLE_D, 4'hF, 1'b0, 1, "link_fill_hi");
    endtask

    task automatic test_underflow();
        int n;
        i_link_up = 1'b1;
        mac_idle();
        n = 0;
        while (o_state !== 2'd2 && n < 300) begin
            next_cycle();
            n++;
        end
        checks++;
        if (n >= 300 || exp_phase() != 0) begin
            errors++;
            $display("FAIL uf_rerun cyc=%0d got state=%0d phase=%0d want RUN at phase 0", cyc,
                     o_state, exp_phase());
        end
        mac_word(IDLE_D, 4'hF, 1'b1, IDLE_D, 4'hF, 1'b0, 2, "uf_pre");
        mac_word(32'h12345678, 4'h0, 1'b0, ERR_D, 4'hF, 1'b1, 2, "uf_word");
        mac_word(IDLE_D, 4'hF, 1'b1, IDLE_D, 4'hF, 1'b0, 2, "uf_post");
        @(negedge i_clk);
        checks++;
        if (o_gearbox_seq !== 6'(exp_seq())) begin
            errors++;
            $display("FAIL uf_seq cyc=%0d got %0d want %0d", cyc, o_gearbox_seq, exp_seq());
        end
        next_cycle();
        align_to(SEQ_MOD - 1, "uf_pause");
        i_mac_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            checks++;
            if ({o_gearbox_pause, o_xgmii_valid, o_mac_ready, o_underflow} !== 4'b1000) begin
                errors++;
                $display("FAIL uf_in_pause cyc=%0d got p/v/r/u=%b%b%b%b want 1000", cyc,
                         o_gearbox_pause, o_xgmii_valid, o_mac_ready, o_underflow);
            end
            next_cycle();
        end
        mac_idle();
    endtask

    task automatic test_reset_mid();
        align_to(6, "rmid");
        mac_word(32'hCAFE0001, 4'h0, 1'b1, 32'hCAFE0001, 4'h0, 1'b0, 2, "rmid_lo");
        i_mac_txd   = 32'hCAFE0002;
        i_mac_txc   = 4'h0;
        i_mac_valid = 1'b1;
        #2;
        checks++;
        if ({o_xgmii_txd, o_xgmii_txc} !== {32'hCAFE0002, 4'h0} || exp_phase() != 1) begin
            errors++;
            $display("FAIL rmid_pre got %h/%h phase=%0d want cafe0002/0 phase=1",
                     o_xgmii_txd, o_xgmii_txc, exp_phase());
        end
        i_reset = 1'b1;
        #1;
        check_reset_outputs("rmid_reset");
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        mac_idle();
        i_reset = 1'b0;
        test_fill_to_run("refill");
    endtask

    task automatic test_disable();
        int exp_st;
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        i_enable  = 1'b1;
        i_link_up = 1'b1;
        mac_idle();
        i_reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (cyc == 4) i_enable = 1'b0;
            @(negedge i_clk);
            exp_st = (cyc < 2) ? 0 : (cyc < 6) ? 1 : 0;
            checks++;
            if ({o_state, o_mac_ready, o_xgmii_valid} !== {2'(exp_st), 2'b11}) begin
                errors++;
                $display("FAIL disable cyc=%0d got state=%0d r=%b v=%b want state=%0d r=1 v=1", cyc,
                         o_state, o_mac_ready, o_xgmii_valid, exp_st);
            end
            next_cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d simulation did not finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill_to_run("fill");
        test_free_run();
        test_frame_over_pause();
        test_link_drop();
        test_underflow();
        test_reset_mid();
        test_disable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
